mult_retire: RTL and testbench

Retirement stage that sits directly downstream of the last `mult_stage` in the 8-stage pipelined multiplier. It captures each finished 64-bit product when the final stage's `done` fires, and re-associates it with the request tag it carries through a parallel tag delay line. It buffers results in a small FIFO behind a valid/ready output handshake. Because the multiplier pipeline cannot stall, the block also issues credit (`issue_ok`) so that upstream never starts more multiplies than the buffer can absorb.

---
 rtl/mult_pkg.sv | 16 +
 rtl/mult_result_fifo.sv | 66 ++++++
 rtl/mult_retire.sv | 110 +++++++++++
 tb/tb_mult_retire.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Types and constants shared by the pipelined multiplier chain and its retirement stage.
package mult_pkg;

    localparam int MULT_NUM_STAGE = 8;
    localparam int MULT_TAG_W     = 4;

    typedef logic [MULT_TAG_W-1:0] mult_tag_t;

    typedef struct packed {
        mult_tag_t   tag;
        logic [63:0] product;
    } mult_result_t;

    localparam int MULT_RESULT_W = $bits(mult_result_t);

endpackage

// File: rtl/mult_result_fifo.sv
// First-word-fall-through result buffer; storage is intentionally left out of reset.
module mult_result_fifo
    import mult_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = MULT_RESULT_W,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             wr_en, rd_en;

    assign full_o  = (count_q == COUNT_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A write on full is only allowed when the head leaves in the same cycle.
    assign rd_en = pop_i && !empty_o;
    assign wr_en = push_i && (!full_o || rd_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/mult_retire.sv
// Retirement stage for the pipelined multiplier: re-tags finished products,
// buffers them behind valid/ready, and issues credit so the non-stalling pipe never overruns.
module mult_retire
    import mult_pkg::*;
#(
    parameter int NUM_STAGE = MULT_NUM_STAGE,
    parameter int DEPTH     = 4,
    parameter int TAG_W     = MULT_TAG_W,
    localparam int CW       = $clog2(DEPTH) + 1
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             issue_i,
    input  logic [TAG_W-1:0] issue_tag_i,
    input  logic             done_in_i,
    input  logic [63:0]      product_in_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [63:0]      out_product_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic             issue_ok_o,
    output logic [CW-1:0]    count_o,
    output logic             sync_err_o,
    output logic             ovf_err_o
);

    localparam logic [CW-1:0] RES_MAX = CW'(DEPTH);
    localparam logic [CW:0]   SUM_MAX = (CW+1)'(DEPTH);

    logic [NUM_STAGE-1:0] vld_q, vld_d;
    logic [TAG_W-1:0]     tag_q [NUM_STAGE];
    logic                 head_vld;
    logic [TAG_W-1:0]     head_tag;

    logic [CW-1:0]        reserved_q, reserved_d;
    logic [CW:0]          res_sum;
    logic                 sync_err_q, sync_err_d;
    logic                 ovf_err_q, ovf_err_d;

    mult_result_t         push_data, head_data;
    logic                 fifo_full, fifo_empty, pop;

    assign vld_d    = {vld_q[NUM_STAGE-2:0], issue_i};
    assign head_vld = vld_q[NUM_STAGE-1];
    assign head_tag = head_vld ? tag_q[NUM_STAGE-1] : '0;

    always_ff @(posedge clock_i) begin
        if (reset_i) vld_q <= '0;
        else         vld_q <= vld_d;
    end

    always_ff @(posedge clock_i) begin
        tag_q[0] <= issue_tag_i;
        for (int i = 1; i < NUM_STAGE; i++) tag_q[i] <= tag_q[i-1];
    end

    assign push_data.tag     = mult_tag_t'(head_tag);
    assign push_data.product = product_in_i;

    mult_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (MULT_RESULT_W)
    ) u_fifo (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .push_i  (done_in_i),
        .pop_i   (pop),
        .data_i  (push_data),
        .data_o  (head_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count_o)
    );

    assign out_valid_o   = !fifo_empty;
    assign pop           = out_valid_o && out_ready_i;
    assign out_product_o = head_data.product;
    assign out_tag_o     = TAG_W'(head_data.tag);

    assign issue_ok_o = (reserved_q < RES_MAX);
    assign sync_err_o = sync_err_q;
    assign ovf_err_o  = ovf_err_q;

    // An illegal issue still counts, then saturates; the floor guards against
    // pops of entries that were pushed without a matching issue.
    always_comb begin
        res_sum = {1'b0, reserved_q} + {{CW{1'b0}}, issue_i};
        if (pop && (res_sum != '0)) res_sum = res_sum - (CW+1)'(1);
        if (res_sum > SUM_MAX) res_sum = SUM_MAX;
        reserved_d = res_sum[CW-1:0];

        sync_err_d = sync_err_q || (done_in_i != head_vld);
        ovf_err_d  = ovf_err_q
                     || (done_in_i && fifo_full && !pop)
                     || (issue_i && !issue_ok_o);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            reserved_q <= '0;
            sync_err_q <= 1'b0;
            ovf_err_q  <= 1'b0;
        end else begin
            reserved_q <= reserved_d;
            sync_err_q <= sync_err_d;
            ovf_err_q  <= ovf_err_d;
        end
    end

endmodule

// File: tb/tb_mult_retire.sv
// Directed bench for mult_retire with an 8-cycle multiplier stand-in driving done/product.
module tb_mult_retire;

    logic        clk;
    logic        rst;
    logic        issue;
    logic [3:0]  tag;
    logic [63:0] iprod;
    logic        inj;
    logic [63:0] inj_prod;
    logic        ready;

    logic        done_in;
    logic [63:0] product_in;
    logic        out_valid;
    logic [63:0] out_product;
    logic [3:0]  out_tag;
    logic        issue_ok;
    logic [2:0]  count;
    logic        sync_err;
    logic        ovf_err;

    int checks;
    int errors;

    logic [7:0]  pv;
    logic [63:0] pp [8];

    mult_retire dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .issue_i       (issue),
        .issue_tag_i   (tag),
        .done_in_i     (done_in),
        .product_in_i  (product_in),
        .out_valid_o   (out_valid),
        .out_ready_i   (ready),
        .out_product_o (out_product),
        .out_tag_o     (out_tag),
        .issue_ok_o    (issue_ok),
        .count_o       (count),
        .sync_err_o    (sync_err),
        .ovf_err_o     (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the multiplier chain: done and product emerge 8 cycles after issue.
    always @(posedge clk) begin
        if (rst) pv <= '0;
        else     pv <= {pv[6:0], issue};
        pp[0] <= iprod;
        for (int i = 1; i < 8; i++) pp[i] <= pp[i-1];
    end

    assign done_in    = pv[7] | inj;
    assign product_in = inj ? inj_prod : pp[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic fill4(input logic [3:0] t0, input logic [63:0] p0);
        for (int i = 0; i < 4; i++) begin
            issue = 1'b1;
            tag   = t0 + 4'(i);
            iprod = p0 + 64'(i);
            tick();
        end
        issue = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; issue = 1'b0; tag = '0; iprod = '0;
        inj = 1'b0; inj_prod = '0; ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_count",     64'(count),     64'd0);
        chk("rst_issue_ok",  64'(issue_ok),  64'd1);
        chk("rst_sync_err",  64'(sync_err),  64'd0);
        chk("rst_ovf_err",   64'(ovf_err),   64'd0);

        // Single result: issue in cycle 0, done in cycle 8, visible in cycle 9.
        ready = 1'b1;
        issue = 1'b1; tag = 4'h3; iprod = 64'h2A;
        tick();
        issue = 1'b0;
        idle(7);
        chk("single_no_bypass", 64'(out_valid), 64'd0);
        tick();
        chk("single_valid",   64'(out_valid), 64'd1);
        chk("single_tag",     64'(out_tag),   64'h3);
        chk("single_product", out_product,    64'h2A);
        tick();
        chk("single_count0", 64'(count),     64'd0);
        chk("single_empty",  64'(out_valid), 64'd0);
        chk("single_sync",   64'(sync_err),  64'd0);
        chk("single_ovf",    64'(ovf_err),   64'd0);

        // Back-to-back fill with consumer stalled.
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) chk("fill_ok_before_last", 64'(issue_ok), 64'd1);
            issue = 1'b1; tag = 4'(i); iprod = 64'h100 + 64'(i);
            tick();
        end
        issue = 1'b0;
        chk("fill_credit_out", 64'(issue_ok), 64'd0);
        idle(8);
        chk("fill_count4",  64'(count),   64'd4);
        chk("fill_head_tag", 64'(out_tag), 64'h0);
        chk("fill_head_prod", out_product, 64'h100);

        // Full FIFO, pop and injected push together.
        ready = 1'b1; inj = 1'b1; inj_prod = 64'hBEEF;
        tick();
        inj = 1'b0;
        chk("pp_count4",     64'(count),    64'd4);
        chk("pp_ovf",        64'(ovf_err),  64'd0);
        chk("pp_credit_back", 64'(issue_ok), 64'd1);
        chk("pp_sync",       64'(sync_err), 64'd1);
        chk("pp_head_tag",   64'(out_tag),  64'h1);
        chk("pp_head_prod",  out_product,   64'h101);
        tick();
        chk("pp_tag2",  64'(out_tag), 64'h2);
        chk("pp_prod2", out_product,  64'h102);
        tick();
        chk("pp_tag3",  64'(out_tag), 64'h3);
        chk("pp_prod3", out_product,  64'h103);
        tick();
        chk("pp_tag_new",  64'(out_tag), 64'h0);
        chk("pp_prod_new", out_product,  64'hBEEF);
        tick();
        chk("pp_drained", 64'(count), 64'd0);
        ready = 1'b0;

        // Misalignment: done in cycle 5 with no matching issue.
        do_reset();
        chk("mis_sync_cleared", 64'(sync_err), 64'd0);
        idle(5);
        inj = 1'b1; inj_prod = 64'h55;
        tick();
        inj = 1'b0;
        chk("mis_sync_set", 64'(sync_err), 64'd1);
        chk("mis_count",    64'(count),    64'd1);
        chk("mis_tag0",     64'(out_tag),  64'h0);
        chk("mis_prod",     out_product,   64'h55);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        idle(3);
        chk("mis_sticky", 64'(sync_err), 64'd1);
        chk("mis_popped", 64'(count),    64'd0);

        // Issue while credit is exhausted.
        do_reset();
        fill4(4'h4, 64'h204);
        chk("ill_no_ovf_yet", 64'(ovf_err),  64'd0);
        chk("ill_credit_out", 64'(issue_ok), 64'd0);
        issue = 1'b1; tag = 4'h9; iprod = 64'h999;
        tick();
        issue = 1'b0;
        chk("ill_ovf",      64'(ovf_err),  64'd1);
        chk("ill_still_out", 64'(issue_ok), 64'd0);
        idle(8);
        chk("ill_drop_count", 64'(count),    64'd4);
        chk("ill_head_tag",   64'(out_tag),  64'h4);
        chk("ill_head_prod",  out_product,   64'h204);
        chk("ill_sync",       64'(sync_err), 64'd0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("ill_saturated", 64'(issue_ok), 64'd1);
        chk("ill_count3",    64'(count),    64'd3);
        chk("ill_next_tag",  64'(out_tag),  64'h5);

        // Push on full with no pop is dropped.
        do_reset();
        chk("drop_ovf_cleared", 64'(ovf_err), 64'd0);
        fill4(4'h1, 64'h301);
        idle(8);
        chk("drop_full", 64'(count), 64'd4);
        inj = 1'b1; inj_prod = 64'hDEAD;
        tick();
        inj = 1'b0;
        chk("drop_count", 64'(count),   64'd4);
        chk("drop_ovf",   64'(ovf_err), 64'd1);
        chk("drop_head",  64'(out_tag), 64'h1);

        // Reset with two issues in flight and one result buffered.
        do_reset();
        issue = 1'b1; tag = 4'hA; iprod = 64'hA0;
        tick();
        issue = 1'b0;
        idle(6);
        issue = 1'b1; tag = 4'hB; iprod = 64'hB0;
        tick();
        tag = 4'hC; iprod = 64'hC0;
        tick();
        issue = 1'b0;
        chk("mf_buffered", 64'(count), 64'd1);
        do_reset();
        chk("mf_count0",   64'(count),     64'd0);
        chk("mf_invalid",  64'(out_valid), 64'd0);
        chk("mf_issue_ok", 64'(issue_ok),  64'd1);
        idle(12);
        chk("mf_no_late_push", 64'(count),    64'd0);
        chk("mf_sync",         64'(sync_err), 64'd0);
        chk("mf_ovf",          64'(ovf_err),  64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
